// File: rtl/zapper_input.sv
// zapper_input: Zapper trigger/photodiode conditioning and frame-locked shot sequencer (one hit or miss per pull).
// Define ZAPPER_DARK_CHECK_EN to add a dark reference frame that vetoes shots aimed at lamps or sky.
module zapper_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HIT_THRESH      = 64,
  parameter int COOL_FRAMES     = 8,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger_in,
  input  logic light_in,
  input  logic frame_start,
  output logic flash_on,
  output logic dark_on,
  output logic hit,
  output logic miss,
  output logic busy,
  output logic trig_db
);

  localparam int FRM_W = (COOL_FRAMES < 2) ? 1 : $clog2(COOL_FRAMES + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(HIT_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [FRM_W-1:0] COOL_LOAD = FRM_W'(COOL_FRAMES);
  localparam logic [FRM_W-1:0] COOL_LAST = FRM_W'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_DARK       = 3'd2,
    S_FLASH      = 3'd3,
    S_DECIDE     = 3'd4,
    S_COOLDOWN   = 3'd5
  } state_t;

  logic             trig_meta_q, trig_sync_q, light_meta_q, light_sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d, light_cnt_q, light_cnt_d, light_inc_s;
  logic [FRM_W-1:0] cool_q, cool_d;
  logic             trig_db_q, trig_db_d, trig_db_dly_q, armed_q, armed_d;
  logic             flash_on_q, flash_on_d, dark_on_q, dark_on_d;
  logic             hit_q, hit_d, miss_q, miss_d, busy_q, busy_d;
  logic             trig_pulled_s, light_act_s, press_s, accept_s, light_seen_s, dark_seen_s;
`ifdef ZAPPER_DARK_CHECK_EN
  logic             dark_seen_q, dark_seen_d;
  assign dark_seen_s = dark_seen_q;
`else
  assign dark_seen_s = 1'b0;
`endif

  // Synchronizers keep sampling through reset so a trigger held across reset is already visible on release.
  always_ff @(posedge clk) begin
    trig_meta_q  <= trigger_in;
    trig_sync_q  <= trig_meta_q;
    light_meta_q <= light_in;
    light_sync_q <= light_meta_q;
  end

  assign trig_pulled_s = ~trig_sync_q;
  assign light_act_s   = ~light_sync_q;
  assign press_s       = trig_db_q & ~trig_db_dly_q;
  assign accept_s      = press_s & armed_q & (state_q == S_IDLE);
  assign light_inc_s   = (light_cnt_q == CNT_MAX) ? light_cnt_q : light_cnt_q + CNT_W'(1);
  assign light_seen_s  = (light_cnt_q >= THRESH);

  // Debounce and arming: re-arm only once the trigger is fully released at both the pin and the debounced level.
  always_comb begin
    db_cnt_d  = '0;
    trig_db_d = trig_db_q;
    armed_d   = armed_q;
    if (trig_pulled_s != trig_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        trig_db_d = ~trig_db_q;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d  = db_cnt_q + CNT_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
    if (accept_s) begin
      armed_d = 1'b0;
    end else if (!trig_db_q && !trig_pulled_s) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // Shot sequencer next state; verdict and output decodes are computed from state_d so they register in step.
  always_comb begin
    state_d     = state_q;
    light_cnt_d = light_cnt_q;
    cool_d      = cool_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
`ifdef ZAPPER_DARK_CHECK_EN
    dark_seen_d = dark_seen_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_WAIT_FRAME;
        else          state_d = S_IDLE;
      end
      S_WAIT_FRAME: begin
        if (frame_start) begin
          light_cnt_d = '0;
`ifdef ZAPPER_DARK_CHECK_EN
          dark_seen_d = 1'b0;
          state_d     = S_DARK;
`else
          state_d     = S_FLASH;
`endif
        end else begin
          state_d = S_WAIT_FRAME;
        end
      end
`ifdef ZAPPER_DARK_CHECK_EN
      S_DARK: begin
        if (frame_start) begin
          dark_seen_d = light_seen_s;
          light_cnt_d = '0;
          state_d     = S_FLASH;
        end else if (light_act_s) begin
          light_cnt_d = light_inc_s;
        end else begin
          light_cnt_d = light_cnt_q;
        end
      end
`endif
      S_FLASH: begin
        if (frame_start) begin
          state_d = S_DECIDE;
          if (light_seen_s && !dark_seen_s) hit_d = 1'b1;
          else                              miss_d = 1'b1;
        end else if (light_act_s) begin
          light_cnt_d = light_inc_s;
        end else begin
          light_cnt_d = light_cnt_q;
        end
      end
      S_DECIDE: begin
        cool_d = COOL_LOAD;
        if (COOL_FRAMES == 0) state_d = S_IDLE;
        else                  state_d = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (frame_start) begin
          if (cool_q <= COOL_LAST) state_d = S_IDLE;
          else                     cool_d  = cool_q - COOL_LAST;
        end else begin
          cool_d = cool_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    flash_on_d = (state_d == S_FLASH);
    busy_d     = (state_d != S_IDLE);
`ifdef ZAPPER_DARK_CHECK_EN
    dark_on_d  = (state_d == S_DARK);
`else
    dark_on_d  = 1'b0;
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      db_cnt_q      <= '0;
      light_cnt_q   <= '0;
      cool_q        <= '0;
      trig_db_q     <= 1'b0;
      trig_db_dly_q <= 1'b0;
      armed_q       <= 1'b0;
      flash_on_q    <= 1'b0;
      dark_on_q     <= 1'b0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      busy_q        <= 1'b0;
`ifdef ZAPPER_DARK_CHECK_EN
      dark_seen_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      light_cnt_q   <= light_cnt_d;
      cool_q        <= cool_d;
      trig_db_q     <= trig_db_d;
      trig_db_dly_q <= trig_db_q;
      armed_q       <= armed_d;
      flash_on_q    <= flash_on_d;
      dark_on_q     <= dark_on_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      busy_q        <= busy_d;
`ifdef ZAPPER_DARK_CHECK_EN
      dark_seen_q   <= dark_seen_d;
`endif
    end
  end

  assign flash_on = flash_on_q;
  assign dark_on  = dark_on_q;
  assign hit      = hit_q;
  assign miss     = miss_q;
  assign busy     = busy_q;
  assign trig_db  = trig_db_q;

endmodule

// File: tb/tb_zapper_input.sv
// tb_zapper_input: directed plus randomized shots against a frame-arithmetic model of the Zapper front end.
`timescale 1ns/1ps
module tb_zapper_input;
  localparam int DB = 4;
  localparam int TH = 3;
  localparam int CF = 2;
  localparam int FP = 100;
`ifdef ZAPPER_DARK_CHECK_EN
  localparam bit DARK_EN = 1'b1;
`else
  localparam bit DARK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, trigger_in, light_in, frame_start;
  logic flash_on, dark_on, hit, miss, busy, trig_db;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wa_s = 0, wa_n = 0, wb_s = 0, wb_n = 0;
  int n_hit, n_miss, n_flash, n_dark, n_busy, n_trig, first_pulse, first_flash;
  int p, f1, f_flash;

  always #5 clk = ~clk;

  zapper_input #(
    .DEBOUNCE_CYCLES(DB),
    .HIT_THRESH(TH),
    .COOL_FRAMES(CF),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trigger_in(trigger_in),
    .light_in(light_in),
    .frame_start(frame_start),
    .flash_on(flash_on),
    .dark_on(dark_on),
    .hit(hit),
    .miss(miss),
    .busy(busy),
    .trig_db(trig_db)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic light_low_at(input int e);
    return ((e >= wa_s) && (e < wa_s + wa_n)) || ((e >= wb_s) && (e < wb_s + wb_n));
  endfunction

  task automatic clear_mon();
    n_hit = 0; n_miss = 0; n_flash = 0; n_dark = 0; n_busy = 0; n_trig = 0;
    first_pulse = -1; first_flash = -1;
  endtask

  // One clock: observe just after the edge, then set inputs for the next edge (frame edges at multiples of FP).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (hit) n_hit++;
    if (miss) n_miss++;
    if ((hit || miss) && first_pulse < 0) first_pulse = cyc;
    if (flash_on) n_flash++;
    if (flash_on && first_flash < 0) first_flash = cyc;
    if (dark_on) n_dark++;
    if (busy) n_busy++;
    if (trig_db) n_trig++;
    frame_start = (((cyc + 1) % FP) == 0);
    light_in    = !light_low_at(cyc + 1);
  endtask

  task automatic run_to(input int e);
    while (cyc < e) tick();
  endtask

  task automatic release_trig(input int n);
    trigger_in = 1'b1;
    repeat (n) tick();
  endtask

  // Pull at edge pull_at, light the flash frame for fl_n cycles and the dark frame for dk_n cycles.
  task automatic do_shot(input int pull_at, input int fl_n, input int dk_n, input string tag);
    int acc, s1, s_flash, s_dec;
    bit exp_hit;
    run_to(pull_at);
    trigger_in = 1'b0;
    acc     = pull_at + 2 + DB + 1;
    s1      = (acc / FP + 1) * FP;
    s_flash = DARK_EN ? s1 + FP : s1;
    s_dec   = s_flash + FP;
    wa_s = s_flash + 10 + int'($urandom_range(0, 30));
    wa_n = fl_n;
    wb_s = s1 + 10 + int'($urandom_range(0, 30));
    wb_n = DARK_EN ? dk_n : 0;
    exp_hit = (fl_n >= TH) && !(DARK_EN && (dk_n >= TH));
    clear_mon();
    run_to(acc - 2);
    check({tag, "_trigdb_before"}, trig_db, 0);
    tick();
    check({tag, "_trigdb_rise"}, trig_db, 1);
    check({tag, "_busy_before"}, busy, 0);
    tick();
    check({tag, "_busy_rise"}, busy, 1);
    run_to(s_dec);
    check({tag, "_hit"}, hit, 32'(exp_hit));
    check({tag, "_miss"}, miss, 32'(!exp_hit));
    run_to(s_dec + CF * FP - 1);
    check({tag, "_busy_cool"}, busy, 1);
    tick();
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_hit_cycles"}, n_hit, 32'(exp_hit));
    check({tag, "_miss_cycles"}, n_miss, 32'(!exp_hit));
    check({tag, "_pulse_time"}, first_pulse, s_dec);
    check({tag, "_flash_len"}, n_flash, FP);
    check({tag, "_flash_rise"}, first_flash, s_flash);
    check({tag, "_dark_len"}, n_dark, DARK_EN ? FP : 0);
  endtask

  initial begin
    rst = 1'b1; trigger_in = 1'b1; light_in = 1'b1; frame_start = 1'b0;
    clear_mon();
    repeat (5) tick();
    check("rst_flash_on", flash_on, 0);
    check("rst_dark_on", dark_on, 0);
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_busy", busy, 0);
    check("rst_trig_db", trig_db, 0);
    rst = 1'b0;

    // Bounce shorter than the debounce window never reaches trig_db.
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      trigger_in = (i % 2 == 1);
      repeat (2) tick();
    end
    trigger_in = 1'b1;
    repeat (20) tick();
    check("bounce_trig_db", n_trig, 0);
    check("bounce_busy", n_busy, 0);

    do_shot(cyc + 10, 10, 0, "hit");
    clear_mon();
    repeat (250) tick();
    check("held_no_reshot", n_busy, 0);
    release_trig(10);
    do_shot(cyc, 2, 0, "miss");
    release_trig(20);
    do_shot(cyc + 10, TH, 0, "at_thresh");
    release_trig(20);
    do_shot(cyc + 10, TH - 1, 0, "below_thresh");
    release_trig(20);
    // Acceptance edge coincides with a frame_start: that frame must not be consumed.
    p = ((cyc + 10) / FP + 1) * FP - 7;
    do_shot(p, 5, 0, "press_on_frame");
    release_trig(20);
    do_shot(cyc + 10, 50, 50, "dark_veto");
    release_trig(20);
    do_shot(cyc + 10, 50, 0, "dark_clean");
    release_trig(20);

    // Reset in the middle of the flash frame with the trigger still held.
    p = cyc + 5;
    run_to(p);
    trigger_in = 1'b0;
    f1 = ((p + 2 + DB + 1) / FP + 1) * FP;
    f_flash = DARK_EN ? f1 + FP : f1;
    wa_s = f_flash + 40; wa_n = 10; wb_n = 0;
    run_to(f_flash + 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_flash_on", flash_on, 0);
    check("midrst_dark_on", dark_on, 0);
    check("midrst_hit", hit, 0);
    check("midrst_miss", miss, 0);
    check("midrst_busy", busy, 0);
    check("midrst_trig_db", trig_db, 0);
    clear_mon();
    repeat (400) tick();
    check("midrst_no_hit", n_hit, 0);
    check("midrst_no_miss", n_miss, 0);
    check("midrst_no_busy", n_busy, 0);
    check("midrst_no_flash", n_flash, 0);
    check("midrst_held_db", trig_db, 1);
    release_trig(20);

    for (int k = 0; k < 6; k++) begin
      int fl, dk;
      fl = int'($urandom_range(0, 8));
      dk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : 0;
      do_shot(cyc + 5 + int'($urandom_range(0, 99)), fl, dk, "rand");
      release_trig(20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/zapper_input.md
# zapper_input

Light-gun front end for the duck_hunt game: conditions the raw Zapper trigger and photodiode lines, runs the shot sequence against VGA frame boundaries, and reports one hit or miss verdict per trigger pull. Sits between the board pins (trigger_in, light_in) and the duck_hunt game logic. It requests flash frames from the renderer and returns single-cycle result pulses.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000: cycles the synchronized trigger must stay stable before the debounced level changes (10 ms at 25 MHz).
- HIT_THRESH, 64: light-active cycles in one frame required for "light seen".
- COOL_FRAMES, 8: frames of lockout after a verdict.
- CNT_W, 20: width of the debounce and light counters.

Ports:
- clk  in  1  pixel clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- trigger_in  in  1  raw Zapper trigger, active-low (0 = pulled), asynchronous.
- light_in  in  1  raw photodiode, active-low (0 = light), asynchronous.
- frame_start  in  1  one-cycle pulse from VGA timing at the first cycle of each frame.
- flash_on  out  1  high for the whole flash frame; renderer draws targets white, rest black.
- dark_on  out  1  high for the whole dark frame (only with ZAPPER_DARK_CHECK_EN, else tied 0).
- hit  out  1  one-cycle pulse: shot verdict hit.
- miss  out  1  one-cycle pulse: shot verdict miss.
- busy  out  1  high in any state other than IDLE.
- trig_db  out  1  debounced trigger, active-high (1 = pulled).

## Operation
- Synchronizers: two-flop sync on trigger_in and light_in. All logic uses the synchronized values.
- Debounce: a counter runs while the synced trigger differs from trig_db and clears when they match. When the counter reaches DEBOUNCE_CYCLES-1, trig_db toggles and the counter clears.
- Arming: the `armed` flag clears on reset and on each accepted press. It sets when trig_db = 0. A press (trig_db 0→1) is accepted only in IDLE with armed = 1.
- FSM states: IDLE, WAIT_FRAME, [DARK], FLASH, DECIDE, COOLDOWN.
  - IDLE: on accepted press, go to WAIT_FRAME.
  - WAIT_FRAME: on frame_start, go to DARK if the macro is defined, else FLASH. Clear the light counter.
  - DARK: count light-active cycles. On frame_start, latch `dark_seen = (count >= HIT_THRESH)`, clear the counter, go to FLASH.
  - FLASH: count light-active cycles. On frame_start, go to DECIDE.
  - DECIDE: takes one cycle. Pulse hit if count >= HIT_THRESH and !dark_seen; otherwise pulse miss. Load the frame counter with COOL_FRAMES, go to COOLDOWN.
  - COOLDOWN: decrement on each frame_start. Go to IDLE on the frame_start that sees the counter at 1. If COOL_FRAMES = 0, go straight to IDLE.
- Light counter saturates at 2^CNT_W-1 and never wraps.
- Press edges outside IDLE are ignored and do not queue.
- Reset: state IDLE; flash_on, dark_on, hit, miss, busy, trig_db all 0. Counters 0, armed 0, dark_seen 0.
  - A trigger held through reset does not fire. The trigger must be released (debounced) before the next shot.

## Timing
- Trigger to trig_db: 2 sync cycles + DEBOUNCE_CYCLES cycles.
- Accepted press to WAIT_FRAME: next cycle. busy rises the same cycle as the state change.
- flash_on and dark_on are registered state decodes. They rise the cycle after the frame_start that enters the state, and fall the cycle after the frame_start that leaves it. The renderer samples them at the frame boundary.
- Light sampling includes the 2-cycle sync latency. The light counter counts from the state-entry cycle through the cycle before the exiting frame_start.
- hit/miss are asserted exactly one cycle, in DECIDE (the cycle after the FLASH-exiting frame_start). Exactly one of the two fires per shot.
- frame_start in the same cycle as a press in IDLE: the press is accepted. That frame_start is not consumed, so WAIT_FRAME waits for the next one.

## Configuration
- ZAPPER_DARK_CHECK_EN defined:
  - DARK state compiled in; one extra frame per shot.
  - A lamp or sky aim that sees light in the dark frame is forced to miss.
- Not defined:
  - No DARK state; dark_on constant 0; dark_seen constant 0.
  - Verdict depends on the flash frame only.

## Test plan
Params for all scenarios: DEBOUNCE_CYCLES=4, HIT_THRESH=3, COOL_FRAMES=2, frame_start every 100 cycles, trigger idle 1, light idle 1.

- Bounce: trigger_in toggles every 2 cycles for 20 cycles, then stays 1 → trig_db stays 0; state stays IDLE.
- Hit: pull trigger; drive light_in = 0 for 10 cycles mid-FLASH → single hit pulse in DECIDE; flash_on high for exactly 100 cycles; busy falls after 2 cooldown frames.
- Miss: pull trigger; light_in = 0 for 2 cycles during FLASH → single miss pulse; no hit.
- Held trigger: keep trigger 0 through the verdict and cooldown → no second shot. Release 10 cycles, pull again → a new shot starts.
- Reset mid-FLASH: assert rst for 1 cycle → next cycle all outputs 0, state IDLE; no hit/miss pulse; trigger still held does not fire.
- With ZAPPER_DARK_CHECK_EN: light_in = 0 for 50 cycles in DARK and 50 cycles in FLASH → miss. Light only in FLASH → hit.
